truth_table_probe: RTL and testbench

Sequential characterizer that recovers the 8-bit truth-table code of any 3-input, 1-output combinational gate. It sweeps the gate's inputs through all eight rows, waits a programmable settle time per row, samples the gate output, and assembles the hex code using the same row/bit convention as the gate library. Truth-table gates map a code to behaviour; this block maps behaviour back to a code, for use in library self-check and regression benches.

---
 rtl/truth_table_probe.sv | 171 +++++++++++++++++
 tb/tb_truth_table_probe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_probe.sv
// rtl/truth_table_probe.sv - sweeps a 3-input gate and recovers its 8-bit truth-table code
// Optional second (verify) pass compiled in with `define TT_PROBE_VERIFY_EN.
module truth_table_probe #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       probe_in1,
  output logic       probe_in2,
  output logic       probe_in3,
  input  logic       probe_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       valid,
  output logic       mismatch
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

`ifdef TT_PROBE_VERIFY_EN
  typedef enum logic [1:0] {IDLE, SWEEP, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SWEEP} state_t;
`endif

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  row;
  logic [7:0]  shadow;
  logic        cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  // Row index drives the gate directly; it wraps back to 000 at the end of each pass,
  // so the pins sit at 000 whenever the block is idle.
  assign {probe_in1, probe_in2, probe_in3} = row;

`ifdef TT_PROBE_VERIFY_EN
  logic diff;
  logic mismatch_q;

  assign mismatch = mismatch_q;

  // Control FSM: first pass captures the code, second pass re-reads every row and
  // flags any disagreement with the captured shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      row        <= 3'd0;
      shadow     <= 8'h00;
      diff       <= 1'b0;
      mismatch_q <= 1'b0;
      code       <= 8'h00;
      valid      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SWEEP;
            cnt        <= 8'd0;
            row        <= 3'd0;
            valid      <= 1'b0;
            mismatch_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt_last) begin
            cnt                 <= 8'd0;
            row                 <= row + 3'd1;
            shadow[3'd7 - row]  <= probe_out;
            if (row == 3'd7) begin
              state <= VERIFY;
              diff  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        VERIFY: begin
          if (cnt_last) begin
            cnt  <= 8'd0;
            row  <= row + 3'd1;
            diff <= diff | (probe_out != shadow[3'd7 - row]);
            if (row == 3'd7) begin
              code       <= shadow;
              valid      <= 1'b1;
              done       <= 1'b1;
              mismatch_q <= diff | (probe_out != shadow[0]);
              // A start present at the completion edge chains straight into the next run.
              if (start) begin
                state <= SWEEP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`else
  assign mismatch = 1'b0;

  // Control FSM: single pass, one sample per row at the end of its settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      row    <= 3'd0;
      shadow <= 8'h00;
      code   <= 8'h00;
      valid  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SWEEP;
            cnt   <= 8'd0;
            row   <= 3'd0;
            valid <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt_last) begin
            cnt                 <= 8'd0;
            row                 <= row + 3'd1;
            shadow[3'd7 - row]  <= probe_out;
            if (row == 3'd7) begin
              // Row 7 lands in bit 0 on this same edge, so merge it into the result.
              code  <= {shadow[7:1], probe_out};
              valid <= 1'b1;
              done  <= 1'b1;
              // A start present at the completion edge chains straight into the next run.
              if (!start) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
// tb/tb_truth_table_probe.sv - directed self-checking bench for truth_table_probe
module tb_truth_table_probe;

`ifdef TT_PROBE_VERIFY_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int S4   = 4;
  localparam int NOM4 = 8 * S4 * PASSES;
  localparam int NOM1 = 8 * PASSES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic       p4_1, p4_2, p4_3, out4;
  logic       busy4, done4, valid4, mm4;
  logic [7:0] code4;
  logic [7:0] gate4 = 8'h00;
  logic       flip5 = 1'b0;
  logic [2:0] pins4;

  logic       start1 = 1'b0;
  logic       p1_1, p1_2, p1_3, out1;
  logic       busy1, done1, valid1, mm1;
  logic [7:0] code1;
  logic [7:0] gate1 = 8'h00;
  logic [2:0] pins1;

  int total = 0;
  int bad   = 0;
  int lat, ndone;

  always #5 clk = ~clk;

  truth_table_probe #(.SETTLE_CYCLES(S4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .probe_in1(p4_1), .probe_in2(p4_2), .probe_in3(p4_3), .probe_out(out4),
    .busy(busy4), .done(done4), .code(code4), .valid(valid4), .mismatch(mm4)
  );

  truth_table_probe #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .probe_in1(p1_1), .probe_in2(p1_2), .probe_in3(p1_3), .probe_out(out1),
    .busy(busy1), .done(done1), .code(code1), .valid(valid1), .mismatch(mm1)
  );

  // Behavioural gates: output bit for row r is code[7-r]; dut4's gate can invert row 5.
  always_comb begin
    pins4 = {p4_1, p4_2, p4_3};
    pins1 = {p1_1, p1_2, p1_3};
    out4  = gate4[3'd7 - pins4] ^ (flip5 && (pins4 == 3'd5));
    out1  = gate1[3'd7 - pins1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run on dut4: optional extra start at E0+poke_at, optional row-5 flip in pass 2.
  task automatic run4(input logic [7:0] gcode, input logic [7:0] old_code, input int poke_at,
                      input bit flip_pass2, output int latency, output int nd);
    gate4 = gcode;
    flip5 = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    check("busy_at_e0", busy4, 1);
    check("mismatch_cleared", mm4, 0);
    latency = -1;
    nd = 0;
    for (int k = 1; k <= NOM4 + 4; k++) begin
      if (k == poke_at) start4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin
        nd++;
        if (latency < 0) latency = k;
      end
      if (k == 5) begin
        check("code_held_midrun", code4, old_code);
        check("valid_low_midrun", valid4, 0);
      end
      if (flip_pass2 && k == 8 * S4) flip5 = 1'b1;
    end
    flip5 = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_valid", valid4, 0);
    check("rst_mismatch", mm4, 0);
    check("rst_code", code4, 8'h00);
    check("rst_pins", pins4, 3'd0);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xCF gate, S=4
    run4(8'hCF, 8'h00, -1, 1'b0, lat, ndone);
    check("cf_latency", lat, NOM4);
    check("cf_ndone", ndone, 1);
    check("cf_code", code4, 8'hCF);
    check("cf_valid", valid4, 1);
    check("cf_mismatch", mm4, 0);
    check("cf_busy_after", busy4, 0);

    // start re-asserted at E0+5 is ignored
    run4(8'h80, 8'hCF, 5, 1'b0, lat, ndone);
    check("poke_latency", lat, NOM4);
    check("poke_ndone", ndone, 1);
    check("poke_code", code4, 8'h80);

    // 0x96 gate, another pattern
    run4(8'h96, 8'h80, -1, 1'b0, lat, ndone);
    check("x96_code", code4, 8'h96);
    check("x96_latency", lat, NOM4);

    // asynchronous reset at E0+10
    gate4 = 8'h5A;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_code", code4, 8'h00);
    check("arst_valid", valid4, 0);
    check("arst_pins", pins4, 3'd0);
    check("arst_done", done4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < NOM4 + 10; k++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run4(8'h5A, 8'h00, -1, 1'b0, lat, ndone);
    check("arst_rerun_code", code4, 8'h5A);
    check("arst_rerun_latency", lat, NOM4);

    // back-to-back S=1: constant 1 then constant 0 with start held high
    gate1 = 8'hFF;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 2 * NOM1; j++) begin
      @(negedge clk);
      check($sformatf("b2b_pins_%0d", j), pins1, j % 8);
      check($sformatf("b2b_done_%0d", j), done1, (j == NOM1 || j == 2 * NOM1) ? 1 : 0);
      if (j == NOM1) begin
        check("b2b_code_ff", code1, 8'hFF);
        check("b2b_busy_chain", busy1, 1);
        gate1  = 8'h00;
        start1 = 1'b0;
      end
      if (j == 2 * NOM1) begin
        check("b2b_code_00", code1, 8'h00);
        check("b2b_busy_end", busy1, 0);
        check("b2b_valid", valid1, 1);
      end
      if (j == 2) check("b2b_valid_low", valid1, 0);
    end

`ifdef TT_PROBE_VERIFY_EN
    // row 5 inverted during the verify pass
    run4(8'hCF, 8'h5A, -1, 1'b1, lat, ndone);
    check("ver_code", code4, 8'hCF);
    check("ver_mismatch", mm4, 1);
    check("ver_latency", lat, NOM4);
    @(negedge clk);
    check("ver_mismatch_sticky", mm4, 1);
    run4(8'h3C, 8'hCF, -1, 1'b0, lat, ndone);
    check("ver_stable_code", code4, 8'h3C);
    check("ver_stable_mismatch", mm4, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait above never returns.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
